// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU between register read and writeback; MUL and DIV iterate one bit per cycle.
// Define ALU_SEQ_DIV_EN to build the restoring divider; without it DIV reports an error like an illegal opcode.

package alu_seq_pkg;
  localparam int unsigned OP_NOT = 0;
  localparam int unsigned OP_AND = 1;
  localparam int unsigned OP_OR  = 2;
  localparam int unsigned OP_XOR = 3;
  localparam int unsigned OP_ADD = 4;
  localparam int unsigned OP_SUB = 5;
  localparam int unsigned OP_MUL = 6;
  localparam int unsigned OP_DIV = 7;
  localparam int unsigned OP_INC = 8;
  localparam int unsigned OP_DEC = 9;
endpackage

module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int WORD_SIZE = 19,
  parameter int OPCODE_W  = 5,
  parameter int CNT_W     = $clog2(WORD_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [WORD_SIZE-1:0] operand_1,
  input  logic [WORD_SIZE-1:0] operand_2,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] result,
  output logic [WORD_SIZE-1:0] remainder,
  output logic                 flag_zero,
  output logic                 flag_neg,
  output logic                 flag_carry,
  output logic                 flag_ovf,
  output logic                 flag_err
);

  localparam int MSB = WORD_SIZE - 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [3:0] {
    K_NOT, K_AND, K_OR, K_XOR, K_ADD, K_SUB, K_INC, K_DEC, K_MUL, K_DIV, K_ILL
  } kind_t;

  state_t               state, state_next;
  kind_t                kind;
  logic                 accept, start_iter, finish_iter, load_out;
  logic                 is_div;
  logic [CNT_W-1:0]     cnt;
  logic [WORD_SIZE-1:0] acc_hi, acc_lo, op_b, iter_hi, iter_lo;
  logic [WORD_SIZE:0]   mul_sum, sum_ext;
  logic [WORD_SIZE-1:0] rhs, sc_result, sc_rem, ld_result, ld_rem;
  logic                 sub_op, sc_carry, sc_ovf, sc_err, ld_carry, ld_ovf, ld_err;
`ifdef ALU_SEQ_DIV_EN
  logic [WORD_SIZE:0]   div_shift, div_trial;
`endif

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin : decode
    kind = K_ILL;
    case (opcode)
      OPCODE_W'(OP_NOT): kind = K_NOT;
      OPCODE_W'(OP_AND): kind = K_AND;
      OPCODE_W'(OP_OR):  kind = K_OR;
      OPCODE_W'(OP_XOR): kind = K_XOR;
      OPCODE_W'(OP_ADD): kind = K_ADD;
      OPCODE_W'(OP_SUB): kind = K_SUB;
      OPCODE_W'(OP_MUL): kind = K_MUL;
      OPCODE_W'(OP_INC): kind = K_INC;
      OPCODE_W'(OP_DEC): kind = K_DEC;
`ifdef ALU_SEQ_DIV_EN
      OPCODE_W'(OP_DIV): kind = K_DIV;
`else
      OPCODE_W'(OP_DIV): kind = K_ILL;
`endif
      default:           kind = K_ILL;
    endcase
    start_iter = (kind == K_MUL) || ((kind == K_DIV) && (operand_2 != '0));
  end

  always_comb begin : single_cycle
    sub_op    = (kind == K_SUB) || (kind == K_DEC);
    rhs       = ((kind == K_INC) || (kind == K_DEC)) ? WORD_SIZE'(1) : operand_2;
    sum_ext   = sub_op ? ({1'b0, operand_1} - {1'b0, rhs}) : ({1'b0, operand_1} + {1'b0, rhs});
    sc_result = '0;
    sc_rem    = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    sc_err    = 1'b0;
    case (kind)
      K_NOT: sc_result = ~operand_1;
      K_AND: sc_result = operand_1 & operand_2;
      K_OR:  sc_result = operand_1 | operand_2;
      K_XOR: sc_result = operand_1 ^ operand_2;
      K_ADD, K_SUB, K_INC, K_DEC: begin
        sc_result = sum_ext[MSB:0];
        sc_carry  = sum_ext[WORD_SIZE];
        // Add overflows on like-signed operands, subtract on unlike-signed, when the result sign flips.
        sc_ovf    = ((operand_1[MSB] ^ rhs[MSB]) == sub_op) && (sum_ext[MSB] != operand_1[MSB]);
      end
      K_DIV: begin
        sc_result = '1;
        sc_rem    = operand_1;
        sc_err    = 1'b1;
      end
      K_MUL:   sc_result = '0;
      default: sc_err    = 1'b1;
    endcase
  end

  // acc_hi:acc_lo is the double-width product for MUL and remainder:quotient for DIV.
  always_comb begin : iterate
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
    iter_hi = mul_sum[WORD_SIZE:1];
    iter_lo = {mul_sum[0], acc_lo[MSB:1]};
`ifdef ALU_SEQ_DIV_EN
    div_shift = {acc_hi, acc_lo[MSB]};
    div_trial = div_shift - {1'b0, op_b};
    if (is_div) begin
      iter_hi = div_trial[WORD_SIZE] ? div_shift[MSB:0] : div_trial[MSB:0];
      iter_lo = {acc_lo[MSB-1:0], ~div_trial[WORD_SIZE]};
    end
`endif
  end

  always_comb begin : load_select
    if (state == S_BUSY) begin
      ld_result = iter_lo;
      ld_rem    = is_div ? iter_hi : '0;
      ld_carry  = 1'b0;
      ld_ovf    = !is_div && (|iter_hi);
      ld_err    = 1'b0;
    end else begin
      ld_result = sc_result;
      ld_rem    = sc_rem;
      ld_carry  = sc_carry;
      ld_ovf    = sc_ovf;
      ld_err    = sc_err;
    end
  end

  always_comb begin : fsm_next
    state_next  = state;
    in_ready    = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    accept      = in_valid && in_ready && !flush;
    finish_iter = (state == S_BUSY) && (cnt == '0) && !flush;
    load_out    = (accept && !start_iter) || finish_iter;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (flush)                               state_next = S_IDLE;
        else if (accept)                         state_next = start_iter ? S_BUSY : S_DONE;
        else if ((state == S_DONE) && out_ready) state_next = S_IDLE;
      end
      S_BUSY: begin
        if (flush)            state_next = S_IDLE;
        else if (cnt == '0)   state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign out_valid = (state == S_DONE);

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: the datapath registers are plain flops, not memories, so they are cleared on reset like the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_hi     <= '0;
      acc_lo     <= '0;
      op_b       <= '0;
      cnt        <= '0;
      is_div     <= 1'b0;
      result     <= '0;
      remainder  <= '0;
      flag_zero  <= 1'b0;
      flag_neg   <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      flag_err   <= 1'b0;
    end else begin
      if (accept && start_iter) begin
        acc_hi <= '0;
        acc_lo <= (kind == K_DIV) ? operand_1 : operand_2;
        op_b   <= (kind == K_DIV) ? operand_2 : operand_1;
        cnt    <= CNT_W'(WORD_SIZE - 1);
        is_div <= (kind == K_DIV);
      end else if ((state == S_BUSY) && !flush) begin
        acc_hi <= iter_hi;
        acc_lo <= iter_lo;
        cnt    <= cnt - CNT_W'(1);
      end
      if (load_out) begin
        result     <= ld_result;
        remainder  <= ld_rem;
        flag_zero  <= (ld_result == '0);
        flag_neg   <= ld_result[MSB];
        flag_carry <= ld_carry;
        flag_ovf   <= ld_ovf;
        flag_err   <= ld_err;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: a vector table plus hand-written backpressure, stream, flush and reset sequences.
// Expected results are queued when an op is driven and compared when the unit hands its result over.
`timescale 1ns/1ps
module tb_alu_seq_unit;
  import alu_seq_pkg::*;

  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, flush, out_valid, out_ready;
  logic [4:0]   opcode;
  logic [W-1:0] operand_1, operand_2, result, remainder;
  logic         flag_zero, flag_neg, flag_carry, flag_ovf, flag_err;

  always #5 clk = ~clk;

  alu_seq_unit #(.WORD_SIZE(W), .OPCODE_W(5)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .operand_1  (operand_1),
    .operand_2  (operand_2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .remainder  (remainder),
    .flag_zero  (flag_zero),
    .flag_neg   (flag_neg),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .flag_err   (flag_err)
  );

  // flags packed as {zero, neg, carry, ovf, err}
  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a, b, res, rem;
    logic [4:0]   flags;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res, rem;
    logic [4:0]   flags;
    int           id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_miss = 0;
  int   next_id = 0;
  int   seen, streak, n_rdy;
  logic [W-1:0]   ra, rb, sa, sb_op;
  logic [2*W-1:0] rp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int unsigned op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic [W-1:0] rem, input logic [4:0] flags,
                         input int lat);
    vec_t v;
    v.op = 5'(op); v.a = a; v.b = b; v.res = res; v.rem = rem; v.flags = flags; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic expect_out(input logic [W-1:0] res, input logic [W-1:0] rem, input logic [4:0] flags);
    exp_t e;
    e.res = res; e.rem = rem; e.flags = flags; e.id = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  // Call just after a rising edge; returns just after the edge that accepted the op.
  task automatic drive(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc = 1'b0;
    opcode = op; operand_1 = a; operand_2 = b; in_valid = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    check($sformatf("accept op%0d", op), 64'(acc), 64'd1);
    #1 in_valid = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    int k = 0;
    expect_out(v.res, v.rem, v.flags);
    drive(v.op, v.a, v.b);
    @(negedge clk);
    while (!out_valid && k < 100) begin
      k++;
      @(negedge clk);
    end
    check($sformatf("latency op%0d a=0x%0h", v.op, v.a), 64'(k), 64'(v.lat));
    @(posedge clk);
    #1;
  endtask

  task automatic watch_no_output(input string name);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(name, 64'(seen), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("result#%0d", mon_e.id), 64'(result), 64'(mon_e.res));
        check($sformatf("remainder#%0d", mon_e.id), 64'(remainder), 64'(mon_e.rem));
        check($sformatf("flags#%0d", mon_e.id),
              64'({flag_zero, flag_neg, flag_carry, flag_ovf, flag_err}), 64'(mon_e.flags));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; operand_1 = '0; operand_2 = '0;
    flush = 1'b0; out_ready = 1'b1;
    #2;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset remainder", 64'(remainder), 64'd0);
    check("reset flags", 64'({flag_zero, flag_neg, flag_carry, flag_ovf, flag_err}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    add_vec(OP_ADD, 19'h7FFFF, 19'h00001, 19'h00000, '0, 5'b10100, 0);
    add_vec(OP_ADD, 19'h3FFFF, 19'h00001, 19'h40000, '0, 5'b01010, 0);
    add_vec(OP_SUB, 19'h00000, 19'h00001, 19'h7FFFF, '0, 5'b01100, 0);
    add_vec(OP_SUB, 19'h40000, 19'h00001, 19'h3FFFF, '0, 5'b00010, 0);
    add_vec(OP_SUB, 19'h00005, 19'h00005, 19'h00000, '0, 5'b10000, 0);
    add_vec(OP_INC, 19'h7FFFF, 19'h55555, 19'h00000, '0, 5'b10100, 0);
    add_vec(OP_INC, 19'h3FFFF, 19'h55555, 19'h40000, '0, 5'b01010, 0);
    add_vec(OP_DEC, 19'h00000, 19'h55555, 19'h7FFFF, '0, 5'b01100, 0);
    add_vec(OP_DEC, 19'h40000, 19'h55555, 19'h3FFFF, '0, 5'b00010, 0);
    add_vec(OP_NOT, 19'h0F0F0, 19'h12345, 19'h70F0F, '0, 5'b01000, 0);
    add_vec(OP_AND, 19'h5A5A5, 19'h0FFFF, 19'h0A5A5, '0, 5'b00000, 0);
    add_vec(OP_OR,  19'h40000, 19'h00001, 19'h40001, '0, 5'b01000, 0);
    add_vec(OP_XOR, 19'h0000F, 19'h000FF, 19'h000F0, '0, 5'b00000, 0);
    add_vec(OP_XOR, 19'h12345, 19'h12345, 19'h00000, '0, 5'b10000, 0);
    add_vec(OP_MUL, 19'd300,   19'd500,   19'h249F0, '0, 5'b00000, W);
    add_vec(OP_MUL, 19'h003FF, 19'h003FF, 19'h7F801, '0, 5'b01010, W);
    add_vec(OP_MUL, 19'h7FFFF, 19'h7FFFF, 19'h00001, '0, 5'b00010, W);
    add_vec(OP_MUL, 19'h00000, 19'h12345, 19'h00000, '0, 5'b10000, W);
`ifdef ALU_SEQ_DIV_EN
    add_vec(OP_DIV, 19'd100,   19'd7,     19'd14,    19'd2, 5'b00000, W);
    add_vec(OP_DIV, 19'd5,     19'd0,     19'h7FFFF, 19'd5, 5'b01001, 0);
    add_vec(OP_DIV, 19'h7FFFF, 19'd3,     19'h2AAAA, 19'd1, 5'b00000, W);
`else
    add_vec(OP_DIV, 19'd100,   19'd7,     19'd0,     19'd0, 5'b10001, 0);
    add_vec(OP_DIV, 19'd5,     19'd0,     19'd0,     19'd0, 5'b10001, 0);
`endif
    add_vec(31, 19'h12345, 19'h00001, 19'h00000, '0, 5'b10001, 0);
    add_vec(10, 19'h00003, 19'h00004, 19'h00000, '0, 5'b10001, 0);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rp = (2*W)'(ra) * (2*W)'(rb);
      add_vec(OP_MUL, ra, rb, rp[W-1:0], '0,
              {rp[W-1:0] == '0, rp[W-1], 1'b0, |rp[2*W-1:W], 1'b0}, W);
      apply_vec(vecs[vecs.size() - 1]);
`ifdef ALU_SEQ_DIV_EN
      rb = W'($urandom_range(1, 2000));
      add_vec(OP_DIV, ra, rb, ra / rb, ra % rb, {(ra / rb) == '0, 1'b0, 3'b000}, W);
      apply_vec(vecs[vecs.size() - 1]);
`endif
    end

    // Backpressure: ADD result held while a queued XOR waits, then both move on release.
    out_ready = 1'b0;
    expect_out(19'd7, '0, 5'b00000);
    drive(5'(OP_ADD), 19'd3, 19'd4);
    opcode = 5'(OP_XOR); operand_1 = 19'h0F; operand_2 = 19'hFF; in_valid = 1'b1;
    expect_out(19'hF0, '0, 5'b00000);
    repeat (3) begin
      @(negedge clk);
      check("bp out_valid held", 64'(out_valid), 64'd1);
      check("bp result held", 64'(result), 64'd7);
      check("bp in_ready low", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp in_ready on release", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp queued op valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // Ten back-to-back SUBs, one accepted and one delivered per cycle.
    streak = 0; n_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 9) begin
        sa = W'(1000 * (i + 1)); sb_op = W'(7 * i);
        expect_out(W'(1000 * (i + 1) - 7 * i), '0, 5'b00000);
      end else begin
        sa = 19'd0; sb_op = 19'd1;
        expect_out(19'h7FFFF, '0, 5'b01100);
      end
      opcode = 5'(OP_SUB); operand_1 = sa; operand_2 = sb_op; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) n_rdy++;
      if (out_valid) streak++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (out_valid) streak++;
    check("stream accepts", 64'(n_rdy), 64'd10);
    check("stream out_valid cycles", 64'(streak), 64'd10);
    @(posedge clk);
    #1;

    // Flush while a result is pending in DONE drops it.
    out_ready = 1'b0;
    drive(5'(OP_ADD), 19'd1, 19'd1);
    @(negedge clk);
    check("flush_done pending", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_done dropped", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Reset five cycles into a MUL.
    drive(5'(OP_MUL), 19'd300, 19'd500);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset in_ready", 64'(in_ready), 64'd1);
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset result", 64'(result), 64'd0);
    check("midreset remainder", 64'(remainder), 64'd0);
    check("midreset flags", 64'({flag_zero, flag_neg, flag_carry, flag_ovf, flag_err}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    watch_no_output("midreset no result");

    // Flush five cycles into an iterative op.
`ifdef ALU_SEQ_DIV_EN
    drive(5'(OP_DIV), 19'd100, 19'd7);
`else
    drive(5'(OP_MUL), 19'd100, 19'd7);
`endif
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy idle", 64'(in_ready), 64'd1);
    check("flush_busy out_valid", 64'(out_valid), 64'd0);
    watch_no_output("flush_busy no result");

    repeat (3) @(posedge clk);
    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
